// File: rtl/motoro301_pkg.sv
// Shared definitions for the motoro301 serial command receiver.
//   - ASCII command byte codes recognised by the decoder
//   - receive FSM state encoding
//   - bit-period divider computation
package motoro301_pkg;

  localparam logic [7:0] CMD_START = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_FSTOP = 8'h58;  // 'X'
  localparam logic [7:0] CMD_CLR   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_INV   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_INC   = 8'h2B;  // '+'
  localparam logic [7:0] CMD_DEC   = 8'h2D;  // '-'

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Clocks per bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core.
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_i         asynchronous serial input, idle high
//   rx_byte_o    last correctly framed byte
//   rx_valid_o   one-cycle strobe, rx_byte_o is new
//   frame_err_o  one-cycle strobe, stop bit sampled low
// Div is the bit period in clocks and must be at least 2.
module uart_rx_core
  import motoro301_pkg::*;
#(
  parameter int unsigned Div = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  // Counter runs N-1 .. 0, so a load of N-1 spans N clocks.
  localparam logic [CntW-1:0] DivFull = CntW'(Div - 1);
  localparam logic [CntW-1:0] DivHalf = CntW'(Div / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  logic            rxs;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            tc;

  assign rxs = rx_sync_q;
  assign tc  = (cnt_q == '0);

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxs) state_d = StStart;
      StStart: if (tc) state_d = rxs ? StIdle : StData;
      StData:  if (tc && (bit_idx_q == 3'd7)) state_d = StStop;
      // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
      StStop:  if (tc) state_d = rxs ? StIdle : StBreak;
      StBreak: if (rxs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / output logic.
  always_comb begin
    cnt_d       = tc ? cnt_q : cnt_q - 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs) cnt_d = DivHalf;
      end
      StStart: begin
        if (tc && !rxs) begin
          cnt_d     = DivFull;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (tc) begin
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = DivFull;
        end
      end
      StStop: begin
        if (tc) begin
          if (rxs) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StBreak: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/motoro301_cmd_rx.sv
// UART command receiver for the motoro301 motor top.
//   clk50mhz     system clock
//   nReset       asynchronous active-low reset
//   uRx          serial input, 8N1, idle high
//   m3start      run request level
//   m3forceStop  force-stop level
//   m3invRotate  rotation direction level
//   m3freqINC    frequency-increment pulse, PULSE_CYC clocks
//   m3freqDEC    frequency-decrement pulse, PULSE_CYC clocks
//   rxByte       last received byte
//   rxValid      one-cycle strobe, rxByte is new
//   frameErr     one-cycle strobe on a low stop bit
//   cmdCnt       recognised command count, wraps
module motoro301_cmd_rx
  import motoro301_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PULSE_CYC = 1_000_000
) (
  input  logic       clk50mhz,
  input  logic       nReset,
  input  logic       uRx,
  output logic       m3start,
  output logic       m3forceStop,
  output logic       m3invRotate,
  output logic       m3freqINC,
  output logic       m3freqDEC,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr,
  output logic [7:0] cmdCnt
);

  localparam int unsigned Div    = calc_div(CLK_HZ, BAUD);
  localparam int unsigned PulseW = (PULSE_CYC > 2) ? $clog2(PULSE_CYC) : 1;
  // Counter runs PULSE_CYC-1 .. 0 while the pulse is high.
  localparam logic [PulseW-1:0] PulseLoad = PulseW'(PULSE_CYC - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid;

  logic              start_q, start_d;
  logic              fstop_q, fstop_d;
  logic              inv_q, inv_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [7:0]        cmd_cnt_q, cmd_cnt_d;
  logic              hit;

  uart_rx_core #(
    .Div (Div)
  ) u_rx (
    .clk_i       (clk50mhz),
    .rst_ni      (nReset),
    .rx_i        (uRx),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frameErr)
  );

  always_comb begin
    start_d     = start_q;
    fstop_d     = fstop_q;
    inv_d       = inv_q;
    inc_d       = inc_q;
    dec_d       = dec_q;
    pulse_cnt_d = pulse_cnt_q;
    hit         = 1'b0;

    // Terminal count ends whichever pulse is active.
    if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - 1'b1;
    end else begin
      inc_d = 1'b0;
      dec_d = 1'b0;
    end

    if (rx_valid) begin
      case (rx_byte)
        CMD_START: begin
          if (!fstop_q) begin
            start_d = 1'b1;
            hit     = 1'b1;
          end
        end
        CMD_STOP: begin
          start_d = 1'b0;
          hit     = 1'b1;
        end
        CMD_FSTOP: begin
          fstop_d = 1'b1;
          start_d = 1'b0;
          hit     = 1'b1;
        end
        CMD_CLR: begin
          fstop_d = 1'b0;
          hit     = 1'b1;
        end
        CMD_INV: begin
          inv_d = ~inv_q;
          hit   = 1'b1;
        end
        // Loading either pulse drops the other on the same edge.
        CMD_INC: begin
          inc_d       = 1'b1;
          dec_d       = 1'b0;
          pulse_cnt_d = PulseLoad;
          hit         = 1'b1;
        end
        CMD_DEC: begin
          inc_d       = 1'b0;
          dec_d       = 1'b1;
          pulse_cnt_d = PulseLoad;
          hit         = 1'b1;
        end
        default: ;
      endcase
    end

    cmd_cnt_d = cmd_cnt_q + {7'd0, hit};
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      start_q     <= 1'b0;
      fstop_q     <= 1'b0;
      inv_q       <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      pulse_cnt_q <= '0;
      cmd_cnt_q   <= 8'h00;
    end else begin
      start_q     <= start_d;
      fstop_q     <= fstop_d;
      inv_q       <= inv_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      pulse_cnt_q <= pulse_cnt_d;
      cmd_cnt_q   <= cmd_cnt_d;
    end
  end

  assign m3start     = start_q;
  assign m3forceStop = fstop_q;
  assign m3invRotate = inv_q;
  assign m3freqINC   = inc_q;
  assign m3freqDEC   = dec_q;
  assign rxByte      = rx_byte;
  assign rxValid     = rx_valid;
  assign cmdCnt      = cmd_cnt_q;

endmodule

// File: tb/tb_motoro301_cmd_rx.sv
// Directed bench for motoro301_cmd_rx. DIV = 1_152_000 / 115_200 = 10 clocks per bit,
// PULSE_CYC = 120 so a pulse outlasts one 100-clock frame and handoff/retrigger are visible.
module tb_motoro301_cmd_rx;

  localparam int unsigned CLK_HZ    = 1_152_000;
  localparam int unsigned BAUD      = 115_200;
  localparam int unsigned PULSE_CYC = 120;
  localparam int          DIV       = 10;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       uRx = 1'b1;
  logic       m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC;
  logic [7:0] rxByte, cmdCnt;
  logic       rxValid, frameErr;

  int total = 0;
  int bad   = 0;

  // Monitor state, sampled on the falling edge.
  int cyc = 0;
  int valid_n = 0, fe_n = 0, overlap = 0;
  int valid_cyc = 0, start_rise = 0;
  int inc_rise = 0, inc_fall = 0, inc_len = 0;
  int dec_rise = 0, dec_fall = 0, dec_len = 0;
  logic start_prev = 1'b0, inc_prev = 1'b0, dec_prev = 1'b0;

  always #5 clk = ~clk;

  motoro301_cmd_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .PULSE_CYC (PULSE_CYC)
  ) dut (
    .clk50mhz    (clk),
    .nReset      (nReset),
    .uRx         (uRx),
    .m3start     (m3start),
    .m3forceStop (m3forceStop),
    .m3invRotate (m3invRotate),
    .m3freqINC   (m3freqINC),
    .m3freqDEC   (m3freqDEC),
    .rxByte      (rxByte),
    .rxValid     (rxValid),
    .frameErr    (frameErr),
    .cmdCnt      (cmdCnt)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rxValid) begin
      valid_n   <= valid_n + 1;
      valid_cyc <= cyc;
    end
    if (frameErr) fe_n <= fe_n + 1;
    if (m3freqINC && m3freqDEC) overlap <= overlap + 1;
    if (m3start && !start_prev) start_rise <= cyc;
    if (m3freqINC && !inc_prev) inc_rise <= cyc;
    if (!m3freqINC && inc_prev) begin
      inc_fall <= cyc;
      inc_len  <= cyc - inc_rise;
    end
    if (m3freqDEC && !dec_prev) dec_rise <= cyc;
    if (!m3freqDEC && dec_prev) begin
      dec_fall <= cyc;
      dec_len  <= cyc - dec_rise;
    end
    start_prev <= m3start;
    inc_prev   <= m3freqINC;
    dec_prev   <= m3freqDEC;
  end

  task automatic drive_bit(input logic lvl);
    uRx = lvl;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    uRx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    uRx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m3start !== 1'b0) begin bad++; $display("FAIL rst_start got %b want 0", m3start); end
    total++; if (m3forceStop !== 1'b0) begin bad++; $display("FAIL rst_fstop got %b want 0", m3forceStop); end
    total++; if (m3invRotate !== 1'b0) begin bad++; $display("FAIL rst_inv got %b want 0", m3invRotate); end
    total++; if ({m3freqINC, m3freqDEC} !== 2'b00) begin bad++; $display("FAIL rst_pulse got %b%b want 00", m3freqINC, m3freqDEC); end
    total++; if ({rxValid, frameErr} !== 2'b00) begin bad++; $display("FAIL rst_strobe got %b%b want 00", rxValid, frameErr); end
    total++; if (rxByte !== 8'h00) begin bad++; $display("FAIL rst_byte got %h want 00", rxByte); end
    total++; if (cmdCnt !== 8'h00) begin bad++; $display("FAIL rst_cnt got %h want 00", cmdCnt); end
    nReset = 1'b1;
    idle(5);
  endtask

  task automatic test_start;
    int t0, v0;
    t0 = cyc;
    v0 = valid_n;
    send_frame(8'h53, 1'b1);
    idle(5);
    total++; if (valid_n - v0 !== 1) begin bad++; $display("FAIL s_valid_cnt got %0d want 1", valid_n - v0); end
    total++; if (rxByte !== 8'h53) begin bad++; $display("FAIL s_byte got %h want 53", rxByte); end
    total++; if ((valid_cyc - t0 < 96) || (valid_cyc - t0 > 98)) begin
      bad++; $display("FAIL s_latency got %0d want 96..98", valid_cyc - t0);
    end
    total++; if (start_rise - valid_cyc !== 1) begin bad++; $display("FAIL s_decode_lat got %0d want 1", start_rise - valid_cyc); end
    total++; if (m3start !== 1'b1) begin bad++; $display("FAIL s_start got %b want 1", m3start); end
    total++; if (cmdCnt !== 8'd1) begin bad++; $display("FAIL s_cnt got %0d want 1", cmdCnt); end
    total++; if ({m3forceStop, m3invRotate, m3freqINC, m3freqDEC} !== 4'b0000) begin
      bad++; $display("FAIL s_others got %b want 0000", {m3forceStop, m3invRotate, m3freqINC, m3freqDEC});
    end
  endtask

  task automatic test_pulse;
    // '+' then '-' back-to-back: frames land 100 clocks apart.
    send_frame(8'h2B, 1'b1);
    send_frame(8'h2D, 1'b1);
    idle(300);
    total++; if (inc_len !== 100) begin bad++; $display("FAIL handoff_inc_len got %0d want 100", inc_len); end
    total++; if (inc_fall !== dec_rise) begin bad++; $display("FAIL handoff_edge got inc_fall=%0d dec_rise=%0d want equal", inc_fall, dec_rise); end
    total++; if (dec_len !== 120) begin bad++; $display("FAIL dec_len got %0d want 120", dec_len); end
    total++; if (cmdCnt !== 8'd3) begin bad++; $display("FAIL pm_cnt got %0d want 3", cmdCnt); end
    // Same command retriggered: one continuous 100 + 120 clock pulse.
    send_frame(8'h2B, 1'b1);
    send_frame(8'h2B, 1'b1);
    idle(300);
    total++; if (inc_len !== 220) begin bad++; $display("FAIL retrig_len got %0d want 220", inc_len); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL inc_dec_overlap got %0d want 0", overlap); end
    total++; if (cmdCnt !== 8'd5) begin bad++; $display("FAIL pp_cnt got %0d want 5", cmdCnt); end
  endtask

  task automatic test_force_stop;
    send_frame(8'h58, 1'b1);
    idle(5);
    total++; if ({m3forceStop, m3start} !== 2'b10) begin bad++; $display("FAIL x_levels got %b want 10", {m3forceStop, m3start}); end
    total++; if (cmdCnt !== 8'd6) begin bad++; $display("FAIL x_cnt got %0d want 6", cmdCnt); end
    send_frame(8'h53, 1'b1);
    idle(5);
    total++; if (m3start !== 1'b0) begin bad++; $display("FAIL xs_start got %b want 0", m3start); end
    total++; if (cmdCnt !== 8'd6) begin bad++; $display("FAIL xs_cnt got %0d want 6", cmdCnt); end
    send_frame(8'h43, 1'b1);
    send_frame(8'h53, 1'b1);
    idle(5);
    total++; if ({m3forceStop, m3start} !== 2'b01) begin bad++; $display("FAIL cs_levels got %b want 01", {m3forceStop, m3start}); end
    total++; if (cmdCnt !== 8'd8) begin bad++; $display("FAIL cs_cnt got %0d want 8", cmdCnt); end
  endtask

  task automatic test_invert;
    send_frame(8'h52, 1'b1);
    idle(5);
    total++; if (m3invRotate !== 1'b1) begin bad++; $display("FAIL r1_inv got %b want 1", m3invRotate); end
    send_frame(8'h52, 1'b1);
    idle(5);
    total++; if (m3invRotate !== 1'b0) begin bad++; $display("FAIL r2_inv got %b want 0", m3invRotate); end
    total++; if (cmdCnt !== 8'd10) begin bad++; $display("FAIL rr_cnt got %0d want 10", cmdCnt); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_n;
    f0 = fe_n;
    send_frame(8'h41, 1'b0);
    uRx = 1'b0;
    repeat (20 * DIV) @(posedge clk);
    #1;
    idle(50);
    total++; if (fe_n - f0 !== 1) begin bad++; $display("FAIL fe_count got %0d want 1", fe_n - f0); end
    total++; if (valid_n - v0 !== 0) begin bad++; $display("FAIL fe_valid got %0d want 0", valid_n - v0); end
    total++; if (rxByte !== 8'h52) begin bad++; $display("FAIL fe_byte got %h want 52", rxByte); end
    total++; if ({m3start, m3forceStop, m3invRotate, cmdCnt} !== {3'b100, 8'd10}) begin
      bad++; $display("FAIL fe_ctrl got %b%b%b cnt=%0d want 100 cnt=10", m3start, m3forceStop, m3invRotate, cmdCnt);
    end
    send_frame(8'h50, 1'b1);
    idle(5);
    total++; if (rxByte !== 8'h50) begin bad++; $display("FAIL p_byte got %h want 50", rxByte); end
    total++; if (m3start !== 1'b0) begin bad++; $display("FAIL p_start got %b want 0", m3start); end
    total++; if (cmdCnt !== 8'd11) begin bad++; $display("FAIL p_cnt got %0d want 11", cmdCnt); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_n;
    f0 = fe_n;
    uRx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(200);
    total++; if ((valid_n - v0 !== 0) || (fe_n - f0 !== 0)) begin
      bad++; $display("FAIL glitch got valid=%0d ferr=%0d want 0 0", valid_n - v0, fe_n - f0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    // '+' leaves a pulse running into the truncated next frame.
    send_frame(8'h2B, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    uRx = 1'b1;
    repeat (DIV / 2) @(posedge clk);
    #1;
    total++; if (m3freqINC !== 1'b1) begin bad++; $display("FAIL mid_inc_pre got %b want 1", m3freqINC); end
    nReset = 1'b0;
    #2;
    total++; if ({m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, rxValid, frameErr} !== 7'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got %b want 0000000",
                      {m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, rxValid, frameErr});
    end
    total++; if ({rxByte, cmdCnt} !== 16'h0000) begin bad++; $display("FAIL mid_rst_regs got %h want 0000", {rxByte, cmdCnt}); end
    repeat (3) @(posedge clk);
    #1;
    nReset = 1'b1;
    v0 = valid_n;
    idle(200);
    total++; if (valid_n - v0 !== 0) begin bad++; $display("FAIL mid_valid got %0d want 0", valid_n - v0); end
    send_frame(8'h53, 1'b1);
    idle(5);
    total++; if (rxByte !== 8'h53) begin bad++; $display("FAIL post_byte got %h want 53", rxByte); end
    total++; if ({m3start, cmdCnt} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL post_start got start=%b cnt=%0d want 1 1", m3start, cmdCnt);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pulse();
    test_force_stop();
    test_invert();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
